arm_alu_seq: RTL and testbench

- Multi-cycle sequencer that owns the arm_alu datapath for data-processing instructions.
- Accepts one instruction at a time over a valid/ready handshake and evaluates its ARM condition code against an internal NZCV register.
- Drives the ALU's opcode, operands and carry-in, registers the ALU result, updates NZCV per the S bit and opcode class, and issues a one-cycle register write-back.
- Sits between decode and the register file / arm_alu.

---
 rtl/arm_alu_pkg.sv | 75 +++++++
 rtl/arm_cond_eval.sv | 36 +++
 rtl/arm_alu_seq.sv | 137 +++++++++++++
 tb/tb_arm_alu_seq.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_alu_pkg.sv
// Shared opcode/condition encodings, sequencer states and flag-update rules
// for the arm_alu sequencer.
package arm_alu_pkg;

  localparam int unsigned OPW   = 5;
  localparam int unsigned CONDW = 4;
  localparam int unsigned NZCVW = 4;

  localparam logic [OPW-1:0] OP_AND  = 5'b00000;
  localparam logic [OPW-1:0] OP_EOR  = 5'b00001;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00010;
  localparam logic [OPW-1:0] OP_RSB  = 5'b00011;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPW-1:0] OP_ADC  = 5'b00101;
  localparam logic [OPW-1:0] OP_SBC  = 5'b00110;
  localparam logic [OPW-1:0] OP_RSC  = 5'b00111;
  localparam logic [OPW-1:0] OP_TST  = 5'b01000;
  localparam logic [OPW-1:0] OP_TEQ  = 5'b01001;
  localparam logic [OPW-1:0] OP_CMP  = 5'b01010;
  localparam logic [OPW-1:0] OP_CMN  = 5'b01011;
  localparam logic [OPW-1:0] OP_ORR  = 5'b01100;
  localparam logic [OPW-1:0] OP_MOV  = 5'b01101;
  localparam logic [OPW-1:0] OP_BIC  = 5'b01110;
  localparam logic [OPW-1:0] OP_MVN  = 5'b01111;
  localparam logic [OPW-1:0] OP_INC4 = 5'b10000;

  localparam logic [CONDW-1:0] COND_EQ = 4'b0000;
  localparam logic [CONDW-1:0] COND_NE = 4'b0001;
  localparam logic [CONDW-1:0] COND_CS = 4'b0010;
  localparam logic [CONDW-1:0] COND_CC = 4'b0011;
  localparam logic [CONDW-1:0] COND_MI = 4'b0100;
  localparam logic [CONDW-1:0] COND_PL = 4'b0101;
  localparam logic [CONDW-1:0] COND_VS = 4'b0110;
  localparam logic [CONDW-1:0] COND_VC = 4'b0111;
  localparam logic [CONDW-1:0] COND_HI = 4'b1000;
  localparam logic [CONDW-1:0] COND_LS = 4'b1001;
  localparam logic [CONDW-1:0] COND_GE = 4'b1010;
  localparam logic [CONDW-1:0] COND_LT = 4'b1011;
  localparam logic [CONDW-1:0] COND_GT = 4'b1100;
  localparam logic [CONDW-1:0] COND_LE = 4'b1101;
  localparam logic [CONDW-1:0] COND_AL = 4'b1110;
  localparam logic [CONDW-1:0] COND_NV = 4'b1111;

  typedef enum logic [2:0] {IDLE, COND, EXEC, WB, RET} state_t;

  // Test/compare ops: always set flags, never write a result.
  function automatic logic op_is_cmp(input logic [OPW-1:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  function automatic logic op_writes(input logic [OPW-1:0] op);
    return !op_is_cmp(op);
  endfunction

  // New NZCV after retirement; move-class and undefined ops leave flags alone.
  function automatic logic [NZCVW-1:0] flag_update(input logic [OPW-1:0]   op,
                                                   input logic             s,
                                                   input logic [NZCVW-1:0] cur,
                                                   input logic [NZCVW-1:0] alu_nzcv,
                                                   input logic             y_msb);
    logic [NZCVW-1:0] nf;
    nf = cur;
    if (s || op_is_cmp(op)) begin
      case (op)
        OP_SUB, OP_RSB, OP_ADD, OP_ADC,
        OP_SBC, OP_RSC, OP_CMP, OP_CMN: nf = alu_nzcv;
        OP_AND, OP_EOR, OP_ORR:         nf = {y_msb, alu_nzcv[2], cur[1:0]};
        OP_TST, OP_TEQ, OP_BIC:         nf = {cur[3], alu_nzcv[2], cur[1:0]};
        default:                        nf = cur;
      endcase
    end
    return nf;
  endfunction

endpackage

// File: rtl/arm_cond_eval.sv
// Combinational ARM condition-code evaluator: cond + NZCV -> pass.
module arm_cond_eval
  import arm_alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass_c
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  // Standard ARM condition table.
  always_comb begin
    pass_c = 1'b0;
    case (cond)
      COND_EQ: pass_c = z;
      COND_NE: pass_c = !z;
      COND_CS: pass_c = c;
      COND_CC: pass_c = !c;
      COND_MI: pass_c = n;
      COND_PL: pass_c = !n;
      COND_VS: pass_c = v;
      COND_VC: pass_c = !v;
      COND_HI: pass_c = c && !z;
      COND_LS: pass_c = !c || z;
      COND_GE: pass_c = (n == v);
      COND_LT: pass_c = (n != v);
      COND_GT: pass_c = !z && (n == v);
      COND_LE: pass_c = z || (n != v);
      COND_AL: pass_c = 1'b1;
      default: pass_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_alu_seq.sv
// Multi-cycle sequencer driving the arm_alu datapath for data-processing
// instructions: condition check, execute, write-back and NZCV update.
// Optional macro ARM_ALU_SEQ_STATS_EN adds executed/skipped retire counters.
module arm_alu_seq
  import arm_alu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_cond,
  input  logic [4:0]    req_op,
  input  logic          req_s,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  input  logic [RW-1:0] req_rd,
  output logic [4:0]    alu_op,
  output logic [DW-1:0] alu_in_1,
  output logic [DW-1:0] alu_in_2,
  output logic          alu_c_in,
  input  logic [DW-1:0] alu_y,
  input  logic          alu_n,
  input  logic          alu_z,
  input  logic          alu_c,
  input  logic          alu_v,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic [3:0]    flags,
  output logic          done,
  output logic          skipped
`ifdef ARM_ALU_SEQ_STATS_EN
  ,
  output logic [31:0]   stat_exec,
  output logic [31:0]   stat_skip
`endif
);

  state_t        state_q;
  logic [3:0]    cond_q;
  logic          s_q;
  logic [RW-1:0] rd_q;
  logic [3:0]    alu_f_q;
  logic          cond_pass_c;
  logic [3:0]    flags_next_c;

  assign req_ready = (state_q == IDLE);
  // Flags only move in WB, so carry-in is stable for the whole EXEC cycle.
  assign alu_c_in  = flags[1];

  arm_cond_eval u_cond_eval (
    .cond   (cond_q),
    .nzcv   (flags),
    .pass_c (cond_pass_c)
  );

  // NZCV candidate from the registered ALU result of the retiring instruction.
  always_comb begin
    flags_next_c = flag_update(alu_op, s_q, flags, alu_f_q, wb_data[DW-1]);
  end

  // Sequencer FSM with registered strobes, operands and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      flags     <= 4'b0000;
      wb_valid  <= 1'b0;
      done      <= 1'b0;
      skipped   <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      alu_op    <= OP_MOV;
      alu_in_1  <= '0;
      alu_in_2  <= '0;
      cond_q    <= 4'b0000;
      s_q       <= 1'b0;
      rd_q      <= '0;
      alu_f_q   <= 4'b0000;
`ifdef ARM_ALU_SEQ_STATS_EN
      stat_exec <= 32'd0;
      stat_skip <= 32'd0;
`endif
    end else begin
      wb_valid <= 1'b0;
      done     <= 1'b0;
      skipped  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            cond_q   <= req_cond;
            alu_op   <= req_op;
            s_q      <= req_s;
            alu_in_1 <= req_a;
            alu_in_2 <= req_b;
            rd_q     <= req_rd;
            state_q  <= COND;
          end
        end
        COND: begin
          if (cond_pass_c) begin
            state_q <= EXEC;
          end else begin
            done    <= 1'b1;
            skipped <= 1'b1;
            state_q <= RET;
          end
        end
        EXEC: begin
          wb_data  <= alu_y;
          alu_f_q  <= {alu_n, alu_z, alu_c, alu_v};
          wb_rd    <= rd_q;
          wb_valid <= op_writes(alu_op);
          done     <= 1'b1;
          state_q  <= WB;
        end
        WB: begin
          flags   <= flags_next_c;
          state_q <= IDLE;
`ifdef ARM_ALU_SEQ_STATS_EN
          stat_exec <= stat_exec + 32'd1;
`endif
        end
        RET: begin
          state_q <= IDLE;
`ifdef ARM_ALU_SEQ_STATS_EN
          stat_skip <= stat_skip + 32'd1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_alu_seq.sv
// Self-checking bench for arm_alu_seq with a behavioural ALU and a
// sequencer reference model tracking NZCV and expected retirement.
module tb_arm_alu_seq;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_cond;
  logic [4:0]    req_op;
  logic          req_s;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic [RW-1:0] req_rd;
  logic [4:0]    alu_op;
  logic [DW-1:0] alu_in_1;
  logic [DW-1:0] alu_in_2;
  logic          alu_c_in;
  logic [DW-1:0] alu_y;
  logic          alu_n, alu_z, alu_c, alu_v;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [3:0]    flags;
  logic          done;
  logic          skipped;
`ifdef ARM_ALU_SEQ_STATS_EN
  logic [31:0]   stat_exec;
  logic [31:0]   stat_skip;
  int            m_exec;
  int            m_skip;
`endif

  int         n_checks;
  int         n_pass;
  logic [3:0] mflags;
  logic [31:0] obs_wb_data;
  logic        obs_c_in;
  logic        obs_skipped;

  arm_alu_seq #(.DW(DW), .RW(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cond  (req_cond),
    .req_op    (req_op),
    .req_s     (req_s),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_rd    (req_rd),
    .alu_op    (alu_op),
    .alu_in_1  (alu_in_1),
    .alu_in_2  (alu_in_2),
    .alu_c_in  (alu_c_in),
    .alu_y     (alu_y),
    .alu_n     (alu_n),
    .alu_z     (alu_z),
    .alu_c     (alu_c),
    .alu_v     (alu_v),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .flags     (flags),
    .done      (done),
    .skipped   (skipped)
`ifdef ARM_ALU_SEQ_STATS_EN
    ,
    .stat_exec (stat_exec),
    .stat_skip (stat_skip)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {y, n, z, c, v}. Logical ops give junk C/V
  // that the sequencer must ignore.
  function automatic logic [35:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
    logic [32:0] sum;
    logic [31:0] x, y, r;
    logic        ci, c, v, arith;
    arith = 1'b1; x = a; y = b; ci = 1'b0;
    case (op)
      5'd2, 5'd10: begin y = ~b; ci = 1'b1; end
      5'd3:        begin x = b; y = ~a; ci = 1'b1; end
      5'd4, 5'd11: ci = 1'b0;
      5'd5:        ci = cin;
      5'd6:        begin y = ~b; ci = cin; end
      5'd7:        begin x = b; y = ~a; ci = cin; end
      default:     arith = 1'b0;
    endcase
    if (arith) begin
      sum = {1'b0, x} + {1'b0, y} + 33'(ci);
      r = sum[31:0];
      c = sum[32];
      v = (x[31] == y[31]) && (r[31] != x[31]);
    end else begin
      case (op)
        5'd0, 5'd8: r = a & b;
        5'd1, 5'd9: r = a ^ b;
        5'd12:      r = a | b;
        5'd14:      r = a & ~b;
        5'd15:      r = ~b;
        5'd16:      r = a + 32'd4;
        default:    r = b;
      endcase
      c = ~b[0];
      v = a[0];
    end
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  always_comb begin
    {alu_y, alu_n, alu_z, alu_c, alu_v} = alu_ref(alu_op, alu_in_1, alu_in_2, alu_c_in);
  end

  function automatic logic cond_ref(input logic [3:0] cd, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cd)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] flags_ref(input logic [4:0] op, input logic s,
                                           input logic [3:0] f, input logic [35:0] res);
    logic [3:0] nf;
    nf = f;
    if (s || (op inside {[5'd8:5'd11]})) begin
      if (op inside {[5'd2:5'd7], 5'd10, 5'd11}) nf = res[3:0];
      else if (op inside {5'd0, 5'd1, 5'd12})    nf = {res[35], res[2], f[1:0]};
      else if (op inside {5'd8, 5'd9, 5'd14})    nf[2] = res[2];
    end
    return nf;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    step();
    rst_n = 1'b1;
    mflags = 4'b0000;
`ifdef ARM_ALU_SEQ_STATS_EN
    m_exec = 0;
    m_skip = 0;
`endif
  endtask

  // Offers one instruction and checks its whole retirement cycle by cycle.
  task automatic do_instr(input logic [3:0] cd, input logic [4:0] op, input logic s,
                          input logic [31:0] a, input logic [31:0] b, input logic [3:0] rd);
    logic        pass, writes;
    logic [35:0] res;
    int          k;
    k = 0;
    while (!req_ready && k < 10) begin step(); k++; end
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL ready_timeout got %b exp 1", req_ready);
    else n_pass++;
    req_cond = cd; req_op = op; req_s = s; req_a = a; req_b = b; req_rd = rd;
    req_valid = 1'b1;
    pass   = cond_ref(cd, mflags);
    res    = alu_ref(op, a, b, mflags[1]);
    writes = !(op inside {[5'd8:5'd11]});
    step();
    req_valid = 1'b0;
    n_checks++;
    if ({req_ready, done, wb_valid} !== 3'b000)
      $display("FAIL cond_cycle got %b exp 000", {req_ready, done, wb_valid});
    else n_pass++;
    step();
    if (!pass) begin
      n_checks++;
      if ({done, skipped, wb_valid} !== 3'b110)
        $display("FAIL skip_retire got %b exp 110", {done, skipped, wb_valid});
      else n_pass++;
      obs_skipped = skipped;
      step();
      n_checks++;
      if ({req_ready, done, flags} !== {2'b10, mflags})
        $display("FAIL skip_after got %b exp %b", {req_ready, done, flags}, {2'b10, mflags});
      else n_pass++;
`ifdef ARM_ALU_SEQ_STATS_EN
      m_skip++;
`endif
    end else begin
      n_checks++;
      if ({done, wb_valid, alu_op, alu_in_1, alu_in_2, alu_c_in} !== {2'b00, op, a, b, mflags[1]})
        $display("FAIL exec_drive got %h exp %h",
                 {done, wb_valid, alu_op, alu_in_1, alu_in_2, alu_c_in},
                 {2'b00, op, a, b, mflags[1]});
      else n_pass++;
      obs_c_in = alu_c_in;
      step();
      n_checks++;
      if ({wb_valid, done, skipped} !== {writes, 2'b10})
        $display("FAIL wb_strobe got %b exp %b", {wb_valid, done, skipped}, {writes, 2'b10});
      else n_pass++;
      if (writes) begin
        n_checks++;
        if ({wb_rd, wb_data} !== {rd, res[35:4]})
          $display("FAIL wb_payload got %h exp %h", {wb_rd, wb_data}, {rd, res[35:4]});
        else n_pass++;
      end
      obs_wb_data = wb_data;
      obs_skipped = skipped;
      mflags = flags_ref(op, s, mflags, res);
      step();
      n_checks++;
      if ({req_ready, done, wb_valid, flags} !== {3'b100, mflags})
        $display("FAIL retire_flags got %b exp %b", {req_ready, done, wb_valid, flags}, {3'b100, mflags});
      else n_pass++;
`ifdef ARM_ALU_SEQ_STATS_EN
      m_exec++;
`endif
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_cond = 4'he; req_op = 5'd4; req_s = 1'b1; req_a = 32'd1; req_b = 32'd2; req_rd = 4'd9;
    step();
    step();
    n_checks++;
    if ({req_ready, flags, wb_valid, done, skipped} !== 8'b1_0000_000)
      $display("FAIL reset_ctrl got %b exp 10000000", {req_ready, flags, wb_valid, done, skipped});
    else n_pass++;
    n_checks++;
    if ({wb_rd, wb_data, alu_op, alu_in_1, alu_in_2} !== {4'd0, 32'd0, 5'b01101, 32'd0, 32'd0})
      $display("FAIL reset_data got %h exp %h", {wb_rd, wb_data, alu_op, alu_in_1, alu_in_2},
               {4'd0, 32'd0, 5'b01101, 32'd0, 32'd0});
    else n_pass++;
    do_reset();
  endtask

  task automatic test_add();
    do_instr(4'b1110, 5'b00100, 1'b1, 32'd5, 32'd7, 4'd3);
    n_checks++;
    if ({obs_wb_data, flags} !== {32'd12, 4'b0000})
      $display("FAIL add_result got %h exp %h", {obs_wb_data, flags}, {32'd12, 4'b0000});
    else n_pass++;
  endtask

  task automatic test_sub_cond();
    do_instr(4'b1110, 5'b00010, 1'b1, 32'd7, 32'd7, 4'd4);
    n_checks++;
    if ({obs_wb_data, flags[2]} !== {32'd0, 1'b1})
      $display("FAIL sub_zero got %h exp %h", {obs_wb_data, flags[2]}, {32'd0, 1'b1});
    else n_pass++;
    do_instr(4'b0000, 5'b00100, 1'b0, 32'd1, 32'd2, 4'd5);
    n_checks++;
    if (obs_skipped !== 1'b0) $display("FAIL addeq_exec got %b exp 0", obs_skipped);
    else n_pass++;
    do_instr(4'b0001, 5'b00100, 1'b0, 32'd1, 32'd2, 4'd6);
    n_checks++;
    if (obs_skipped !== 1'b1) $display("FAIL addne_skip got %b exp 1", obs_skipped);
    else n_pass++;
  endtask

  task automatic test_cmp_lt();
    do_instr(4'b1110, 5'b01010, 1'b0, 32'd3, 32'd9, 4'd7);
    n_checks++;
    if (flags[3:2] !== 2'b10) $display("FAIL cmp_nz got %b exp 10", flags[3:2]);
    else n_pass++;
    do_instr(4'b1011, 5'b01101, 1'b0, 32'd0, 32'h55, 4'd8);
    n_checks++;
    if (obs_skipped !== 1'b0) $display("FAIL lt_pass got %b exp 0", obs_skipped);
    else n_pass++;
  endtask

  task automatic test_adc_carry();
    do_instr(4'b1110, 5'b01010, 1'b0, 32'd9, 32'd3, 4'd0);
    do_instr(4'b1110, 5'b00101, 1'b0, 32'd1, 32'd1, 4'd2);
    n_checks++;
    if ({obs_c_in, obs_wb_data} !== {1'b1, 32'd3})
      $display("FAIL adc_carry got %h exp %h", {obs_c_in, obs_wb_data}, {1'b1, 32'd3});
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 4) == 0) a = 32'h8000_0000 | a;
      do_instr(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               a, b, 4'($urandom));
    end
  endtask

  // Holds req_valid high throughout; acceptances must be exactly exp_gap apart.
  task automatic test_back_to_back(input logic [3:0] cd, input int exp_gap, input int exp_hs);
    int  last, hs_count, k;
    logic hs;
    last = -1; hs_count = 0;
    k = 0;
    while (!req_ready && k < 10) begin step(); k++; end
    req_cond = cd; req_op = 5'd4; req_s = 1'b0; req_a = $urandom; req_b = $urandom; req_rd = 4'd1;
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 13; cyc++) begin
      hs = req_ready;
      step();
      if (hs) begin
        if (last >= 0) begin
          n_checks++;
          if (cyc - last !== exp_gap) $display("FAIL b2b_gap got %0d exp %0d", cyc - last, exp_gap);
          else n_pass++;
        end
        last = cyc;
        hs_count++;
      end
    end
    req_valid = 1'b0;
    n_checks++;
    if (hs_count !== exp_hs) $display("FAIL b2b_count got %0d exp %0d", hs_count, exp_hs);
    else n_pass++;
    k = 0;
    while (!req_ready && k < 8) begin step(); k++; end
    n_checks++;
    if ({req_ready, flags} !== {1'b1, mflags})
      $display("FAIL b2b_drain got %b exp %b", {req_ready, flags}, {1'b1, mflags});
    else n_pass++;
`ifdef ARM_ALU_SEQ_STATS_EN
    if (cd == 4'b1111) m_skip += hs_count;
    else m_exec += hs_count;
`endif
  endtask

  task automatic test_reset_mid_exec();
    do_instr(4'b1110, 5'b01010, 1'b0, 32'd3, 32'd9, 4'd0);
    req_cond = 4'b1110; req_op = 5'b00010; req_s = 1'b1; req_a = 32'd7; req_b = 32'd7; req_rd = 4'd10;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    n_checks++;
    if ({req_ready, alu_op, flags} !== {1'b0, 5'b00010, 4'b1000})
      $display("FAIL in_exec got %b exp %b", {req_ready, alu_op, flags}, {1'b0, 5'b00010, 4'b1000});
    else n_pass++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if ({req_ready, flags, wb_valid, done, skipped} !== 8'b1_0000_000)
      $display("FAIL abort_state got %b exp 10000000", {req_ready, flags, wb_valid, done, skipped});
    else n_pass++;
    step();
    n_checks++;
    if ({req_ready, flags, wb_valid, done} !== 7'b1_0000_00)
      $display("FAIL abort_after got %b exp 1000000", {req_ready, flags, wb_valid, done});
    else n_pass++;
    mflags = 4'b0000;
`ifdef ARM_ALU_SEQ_STATS_EN
    m_exec = 0;
    m_skip = 0;
`endif
  endtask

`ifdef ARM_ALU_SEQ_STATS_EN
  task automatic test_stats();
    n_checks++;
    if ({stat_exec, stat_skip} !== {32'(m_exec), 32'(m_skip)})
      $display("FAIL stats_run got %h exp %h", {stat_exec, stat_skip}, {32'(m_exec), 32'(m_skip)});
    else n_pass++;
    do_reset();
    for (int i = 0; i < 3; i++) do_instr(4'b1110, 5'b01101, 1'b0, 32'd0, 32'(i), 4'd1);
    for (int i = 0; i < 2; i++) do_instr(4'b1111, 5'b01101, 1'b0, 32'd0, 32'(i), 4'd1);
    n_checks++;
    if ({stat_exec, stat_skip} !== {32'd3, 32'd2})
      $display("FAIL stats_3_2 got %h exp %h", {stat_exec, stat_skip}, {32'd3, 32'd2});
    else n_pass++;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0; mflags = 4'b0000;
    obs_wb_data = '0; obs_c_in = 1'b0; obs_skipped = 1'b0;
`ifdef ARM_ALU_SEQ_STATS_EN
    m_exec = 0; m_skip = 0;
`endif
    rst_n = 1'b0; req_valid = 1'b0; req_cond = '0; req_op = '0; req_s = 1'b0;
    req_a = '0; req_b = '0; req_rd = '0;
    test_reset();
    test_add();
    test_sub_cond();
    test_cmp_lt();
    test_adc_carry();
    test_random();
    test_back_to_back(4'b1110, 4, 4);
    test_back_to_back(4'b1111, 3, 5);
`ifdef ARM_ALU_SEQ_STATS_EN
    test_stats();
`endif
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
